// File: rtl/ps2mouse_pkg.sv
// ps2mouse_pos shared types: FSM states, FIFO word fields, status layout.
// Optional wheel accumulation is enabled with PS2MOUSE_WHEEL_EN.
package ps2mouse_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_X,
    S_Y,
    S_PUB
  } state_t;

  localparam int WORD_W = 27;
  localparam int BTN_LSB = 24;
  localparam int BTN_W = 3;
  localparam int DX_LSB = 16;
  localparam int DY_LSB = 8;
  localparam int DZ_LSB = 0;
  localparam int D_W = 8;

  localparam int ST_X_LSB = 0;
  localparam int ST_Y_LSB = 11;
  localparam int ST_WHL_LSB = 24;
  localparam int ST_BTN_LSB = 28;
  localparam int ST_FLD_W = 11;

endpackage

// File: rtl/ps2mouse_axis_clamp.sv
// One cursor axis: base +/- signed 8-bit delta, clamped to 0..max.
// Combinational; shared between the x and y steps of ps2mouse_pos.
module ps2mouse_axis_clamp
  import ps2mouse_pkg::*;
#(
  parameter int POS_W = 11
) (
  input  logic [POS_W-1:0] i_base,
  input  logic [D_W-1:0]   i_delta,
  input  logic             i_sub,
  input  logic [POS_W-1:0] i_max,
  output logic [POS_W-1:0] o_res
);

  localparam int SW = POS_W + 2;

  logic signed [SW-1:0] w_base;
  logic signed [SW-1:0] w_delta;
  logic signed [SW-1:0] w_max;
  logic signed [SW-1:0] w_sum;

  assign w_base = $signed({2'b00, i_base});
  assign w_max = $signed({2'b00, i_max});
  assign w_delta = $signed({{(SW-D_W){i_delta[D_W-1]}}, i_delta});
  assign w_sum = i_sub ? (w_base - w_delta) : (w_base + w_delta);

  // saturate the widened sum into the legal range
  always_comb begin
    o_res = w_sum[POS_W-1:0];
    if (w_sum < 0)
      o_res = '0;
    else if (w_sum > w_max)
      o_res = i_max;
  end

endmodule

// File: rtl/ps2mouse_pos.sv
// Pops ps2mouse motion words and integrates them into a clamped cursor.
// Wheel accumulation is built only when PS2MOUSE_WHEEL_EN is defined.
module ps2mouse_pos
  import ps2mouse_pkg::*;
#(
  parameter int X_MAX = 1023,
  parameter int Y_MAX = 767,
  parameter int POS_W = 11
) (
  input  logic              clk,
  input  logic              ps2m_reset,
  input  logic              rdy,
  input  logic [WORD_W-1:0] data,
  output logic              done,
  input  logic              set_en,
  input  logic [POS_W-1:0]  set_x,
  input  logic [POS_W-1:0]  set_y,
  output logic [POS_W-1:0]  pos_x,
  output logic [POS_W-1:0]  pos_y,
  output logic [BTN_W-1:0]  btn,
  output logic [D_W-1:0]    wheel,
  output logic              upd,
  output logic [31:0]       status
);

  localparam logic [POS_W-1:0] XM = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YM = POS_W'(Y_MAX);

  state_t r_state;
  state_t w_next;

  logic [WORD_W-1:0] r_word;
  logic [POS_W-1:0]  r_nx;
  logic [POS_W-1:0]  r_ny;
  logic [POS_W-1:0]  r_pos_x;
  logic [POS_W-1:0]  r_pos_y;
  logic [BTN_W-1:0]  r_btn;
  logic [D_W-1:0]    w_wheel;

  logic              w_is_y;
  logic [POS_W-1:0]  w_base;
  logic [POS_W-1:0]  w_max;
  logic [D_W-1:0]    w_delta;
  logic [POS_W-1:0]  w_clamp;
  logic [POS_W-1:0]  w_set_x;
  logic [POS_W-1:0]  w_set_y;
  logic [ST_FLD_W-1:0] w_x11;
  logic [ST_FLD_W-1:0] w_y11;

  // one clamp unit serves x in S_X and y in S_Y
  assign w_is_y = (r_state == S_Y);
  assign w_base = w_is_y ? r_pos_y : r_pos_x;
  assign w_max = w_is_y ? YM : XM;
  assign w_delta = w_is_y ? r_word[DY_LSB +: D_W]
                          : r_word[DX_LSB +: D_W];

  ps2mouse_axis_clamp #(
    .POS_W(POS_W)
  ) u_clamp (
    .i_base (w_base),
    .i_delta(w_delta),
    .i_sub  (w_is_y),
    .i_max  (w_max),
    .o_res  (w_clamp)
  );

  assign w_set_x = (set_x > XM) ? XM : set_x;
  assign w_set_y = (set_y > YM) ? YM : set_y;

  // next-state: linear walk, preset aborts to idle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (rdy) w_next = S_POP;
      S_POP:  w_next = S_X;
      S_X:    w_next = S_Y;
      S_Y:    w_next = S_PUB;
      S_PUB:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (set_en)
      w_next = S_IDLE;
  end

  // reset kills done in the same cycle so the FIFO keeps its head
  assign done = (r_state == S_POP) && !ps2m_reset;
  assign upd = (r_state == S_PUB) && !set_en && !ps2m_reset;

  // state, working word, staged coordinates and published outputs
  always_ff @(posedge clk) begin
    if (ps2m_reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_nx    <= '0;
      r_ny    <= '0;
      r_pos_x <= '0;
      r_pos_y <= '0;
      r_btn   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_POP)
        r_word <= data;
      if (r_state == S_X)
        r_nx <= w_clamp;
      if (r_state == S_Y)
        r_ny <= w_clamp;
      if (set_en) begin
        r_pos_x <= w_set_x;
        r_pos_y <= w_set_y;
      end else if (r_state == S_PUB) begin
        r_pos_x <= r_nx;
        r_pos_y <= r_ny;
        r_btn   <= r_word[BTN_LSB +: BTN_W];
      end
    end
  end

`ifdef PS2MOUSE_WHEEL_EN
  logic [D_W-1:0] r_wheel;

  // wheel wraps modulo 256 on each published word
  always_ff @(posedge clk) begin
    if (ps2m_reset)
      r_wheel <= '0;
    else if (r_state == S_PUB && !set_en)
      r_wheel <= r_wheel + r_word[DZ_LSB +: D_W];
  end

  assign w_wheel = r_wheel;
`else
  logic w_dz_unused;
  assign w_dz_unused = ^r_word[DZ_LSB +: D_W];
  assign w_wheel = '0;
`endif

  assign w_x11 = ST_FLD_W'(r_pos_x);
  assign w_y11 = ST_FLD_W'(r_pos_y);

  assign pos_x = r_pos_x;
  assign pos_y = r_pos_y;
  assign btn = r_btn;
  assign wheel = w_wheel;
  assign status = {1'b0, r_btn, w_wheel[3:0], 2'b00, w_y11, w_x11};

endmodule

// File: tb/tb_ps2mouse_pos.sv
// Self-checking bench for ps2mouse_pos with a queue-backed FIFO model.
// Define PS2MOUSE_WHEEL_EN for both bench and RTL to cover the wheel.
module tb_ps2mouse_pos;

  logic        clk = 1'b0;
  logic        ps2m_reset;
  logic        rdy = 1'b0;
  logic [26:0] data = '0;
  logic        done;
  logic        set_en;
  logic [10:0] set_x;
  logic [10:0] set_y;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic [2:0]  btn;
  logic [7:0]  wheel;
  logic        upd;
  logic [31:0] status;

  int n_chk = 0;
  int n_pass = 0;

  logic [26:0] q[$];
  int          done_times[$];
  logic        pop_pend = 1'b0;
  int          cyc = 0;
  int          cnt_done = 0;
  int          cnt_upd = 0;

  int          mx, my;
  logic [2:0]  mb;
  logic [7:0]  mw;

  ps2mouse_pos dut (
    .clk       (clk),
    .ps2m_reset(ps2m_reset),
    .rdy       (rdy),
    .data      (data),
    .done      (done),
    .set_en    (set_en),
    .set_x     (set_x),
    .set_y     (set_y),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .btn       (btn),
    .wheel     (wheel),
    .upd       (upd),
    .status    (status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    pop_pend <= done;
    if (done) begin
      cnt_done <= cnt_done + 1;
      done_times.push_back(cyc);
    end
    if (upd)
      cnt_upd <= cnt_upd + 1;
  end

  always @(posedge clk) begin
    #1;
    if (pop_pend && q.size() != 0)
      void'(q.pop_front());
    rdy = (q.size() != 0);
    data = (q.size() != 0) ? q[0] : 27'd0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [26:0] mk(logic [2:0] b, logic [7:0] dx,
                                     logic [7:0] dy, logic [7:0] dz);
    return {b, dx, dy, dz};
  endfunction

  task automatic model_word(input logic [26:0] w);
    int dx;
    int dy;
    dx = $signed(w[23:16]);
    dy = $signed(w[15:8]);
    mx = clampi(mx + dx, 1023);
    my = clampi(my - dy, 767);
    mb = w[26:24];
`ifdef PS2MOUSE_WHEEL_EN
    mw = mw + w[7:0];
`endif
  endtask

  function automatic logic [31:0] exp_status();
    logic [10:0] x11;
    logic [10:0] y11;
    x11 = 11'(mx);
    y11 = 11'(my);
    return {1'b0, mb, mw[3:0], 2'b00, y11, x11};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_preset(input int x, input int y);
    set_en = 1'b1;
    set_x = 11'(x);
    set_y = 11'(y);
    step();
    set_en = 1'b0;
    mx = clampi(x, 1023);
    my = clampi(y, 767);
  endtask

  task automatic do_reset();
    ps2m_reset = 1'b1;
    step();
    step();
    ps2m_reset = 1'b0;
    q.delete();
    mx = 0;
    my = 0;
    mb = '0;
    mw = '0;
    step();
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    repeat (6) step();
    n_chk++;
    if (n >= 200)
      $display("FAIL %s_idle got timeout exp drained", nm);
    else
      n_pass++;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    n_chk++;
    if (n >= 50)
      $display("FAIL %s_done got timeout exp pulse", nm);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({pos_x, pos_y, btn, wheel, done, upd, status} !== '0)
      $display("FAIL reset_init got %0d/%0d/%0d/%0d/%0d/%0d exp zero",
               pos_x, pos_y, btn, wheel, done, upd);
    else
      n_pass++;
    do_preset(300, 200);
    q.push_back(mk(3'd7, 8'd4, 8'd4, 8'd3));
    model_word(mk(3'd7, 8'd4, 8'd4, 8'd3));
    wait_idle("reset_pre");
    q.push_back(mk(3'd5, 8'd9, 8'd9, 8'd1));
    wait_done("reset_mid");
    ps2m_reset = 1'b1;
    #1;
    n_chk++;
    if (done !== 1'b0)
      $display("FAIL reset_done_drop got %0d exp 0", done);
    else
      n_pass++;
    step();
    step();
    ps2m_reset = 1'b0;
    q.delete();
    mx = 0;
    my = 0;
    mb = '0;
    mw = '0;
    step();
    n_chk++;
    if ({pos_x, pos_y, btn, wheel, upd, status} !== '0)
      $display("FAIL reset_mid got %0d/%0d/%0d/%0d/%0d exp zero",
               pos_x, pos_y, btn, wheel, upd);
    else
      n_pass++;
  endtask

  task automatic test_basic();
    int d0;
    int u0;
    int ox;
    do_preset(100, 100);
    ox = mx;
    d0 = cnt_done;
    u0 = cnt_upd;
    q.push_back(mk(3'b001, 8'd10, 8'd5, 8'd0));
    model_word(mk(3'b001, 8'd10, 8'd5, 8'd0));
    wait_done("basic");
    step();
    step();
    step();
    n_chk++;
    if (upd !== 1'b1 || pos_x !== 11'(ox))
      $display("FAIL basic_pub got upd=%0d x=%0d exp upd=1 x=%0d",
               upd, pos_x, ox);
    else
      n_pass++;
    step();
    n_chk++;
    if (pos_x !== 11'(mx) || pos_y !== 11'(my) || btn !== mb || upd !== 1'b0)
      $display("FAIL basic_pos got %0d,%0d b%0d u%0d exp %0d,%0d b%0d u0",
               pos_x, pos_y, btn, upd, mx, my, mb);
    else
      n_pass++;
    repeat (4) step();
    n_chk++;
    if (cnt_done - d0 != 1 || cnt_upd - u0 != 1)
      $display("FAIL basic_pulses got d%0d u%0d exp d1 u1",
               cnt_done - d0, cnt_upd - u0);
    else
      n_pass++;
  endtask

  task automatic test_clamp();
    int px[4] = '{50, 1000, 500, 500};
    int py[4] = '{300, 300, 2, 760};
    logic [7:0] dx[4] = '{8'h80, 8'h7F, 8'h00, 8'h00};
    logic [7:0] dy[4] = '{8'h00, 8'h00, 8'd100, 8'h80};
    int ex[4] = '{0, 1023, 500, 500};
    int ey[4] = '{300, 300, 0, 767};
    for (int i = 0; i < 4; i++) begin
      do_preset(px[i], py[i]);
      q.push_back(mk(3'd0, dx[i], dy[i], 8'd0));
      model_word(mk(3'd0, dx[i], dy[i], 8'd0));
      wait_idle("clamp");
      n_chk++;
      if (pos_x !== 11'(ex[i]) || pos_y !== 11'(ey[i]))
        $display("FAIL clamp_%0d got %0d,%0d exp %0d,%0d",
                 i, pos_x, pos_y, ex[i], ey[i]);
      else
        n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    int u0;
    int t0;
    do_preset(10, 10);
    d0 = cnt_done;
    u0 = cnt_upd;
    t0 = done_times.size();
    repeat (3) begin
      q.push_back(mk(3'd2, 8'd1, 8'd0, 8'd0));
      model_word(mk(3'd2, 8'd1, 8'd0, 8'd0));
    end
    wait_idle("b2b");
    n_chk++;
    if (pos_x !== 11'd13 || pos_x !== 11'(mx))
      $display("FAIL b2b_x got %0d exp 13", pos_x);
    else
      n_pass++;
    n_chk++;
    if (cnt_done - d0 != 3 || cnt_upd - u0 != 3)
      $display("FAIL b2b_pulses got d%0d u%0d exp d3 u3",
               cnt_done - d0, cnt_upd - u0);
    else
      n_pass++;
    n_chk++;
    if (done_times.size() < t0 + 3)
      $display("FAIL b2b_gap got %0d pulses exp 3", done_times.size() - t0);
    else if (done_times[t0+1] - done_times[t0] != 5 ||
             done_times[t0+2] - done_times[t0+1] != 5)
      $display("FAIL b2b_gap got %0d,%0d exp 5,5",
               done_times[t0+1] - done_times[t0],
               done_times[t0+2] - done_times[t0+1]);
    else
      n_pass++;
  endtask

  task automatic test_preset();
    int u0;
    logic [2:0] b0;
    do_preset(400, 400);
    b0 = mb;
    u0 = cnt_upd;
    q.push_back(mk(3'd6, 8'd20, 8'd20, 8'd0));
    wait_done("preset");
    step();
    set_en = 1'b1;
    set_x = 11'd2000;
    set_y = 11'd900;
    step();
    set_en = 1'b0;
    mx = clampi(2000, 1023);
    my = clampi(900, 767);
    repeat (8) step();
    n_chk++;
    if (pos_x !== 11'(mx) || pos_y !== 11'(my) || btn !== b0)
      $display("FAIL preset_pos got %0d,%0d b%0d exp %0d,%0d b%0d",
               pos_x, pos_y, btn, mx, my, b0);
    else
      n_pass++;
    n_chk++;
    if (cnt_upd != u0)
      $display("FAIL preset_upd got %0d exp 0", cnt_upd - u0);
    else
      n_pass++;
    q.push_back(mk(b0, 8'hFD, 8'd0, 8'd0));
    model_word(mk(b0, 8'hFD, 8'd0, 8'd0));
    wait_idle("preset_after");
    n_chk++;
    if (pos_x !== 11'(mx) || cnt_upd - u0 != 1)
      $display("FAIL preset_resume got x%0d u%0d exp x%0d u1",
               pos_x, cnt_upd - u0, mx);
    else
      n_pass++;
  endtask

  task automatic test_wheel();
    logic [7:0] ew;
`ifdef PS2MOUSE_WHEEL_EN
    ew = 8'hFE;
`else
    ew = 8'h00;
`endif
    do_reset();
    repeat (2) begin
      q.push_back(mk(3'd0, 8'd0, 8'd0, 8'hFF));
      model_word(mk(3'd0, 8'd0, 8'd0, 8'hFF));
    end
    wait_idle("wheel");
    n_chk++;
    if (wheel !== ew || wheel !== mw)
      $display("FAIL wheel got %0h exp %0h", wheel, ew);
    else
      n_pass++;
    n_chk++;
    if (status[27:24] !== ew[3:0])
      $display("FAIL wheel_status got %0h exp %0h", status[27:24], ew[3:0]);
    else
      n_pass++;
  endtask

  task automatic test_random();
    logic [26:0] w;
    logic [7:0]  dx;
    logic [7:0]  dy;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_preset(int'($urandom_range(0, 2047)),
                  int'($urandom_range(0, 2047)));
      dx = 8'($urandom);
      dy = 8'($urandom);
      if ($urandom_range(0, 3) == 0) dx = $urandom_range(0, 1) ? 8'h80 : 8'h7F;
      if ($urandom_range(0, 3) == 0) dy = $urandom_range(0, 1) ? 8'h80 : 8'h7F;
      w = mk(3'($urandom), dx, dy, 8'($urandom));
      q.push_back(w);
      model_word(w);
      wait_idle("rand");
      n_chk++;
      if (pos_x !== 11'(mx) || pos_y !== 11'(my) ||
          btn !== mb || wheel !== mw)
        $display("FAIL rand_%0d got %0d,%0d b%0d w%0h exp %0d,%0d b%0d w%0h",
                 i, pos_x, pos_y, btn, wheel, mx, my, mb, mw);
      else
        n_pass++;
      n_chk++;
      if (status !== exp_status())
        $display("FAIL rand_status_%0d got %08h exp %08h",
                 i, status, exp_status());
      else
        n_pass++;
    end
  endtask

  initial begin
    ps2m_reset = 1'b1;
    set_en = 1'b0;
    set_x = '0;
    set_y = '0;
    mx = 0;
    my = 0;
    mb = '0;
    mw = '0;
    repeat (3) step();
    ps2m_reset = 1'b0;
    step();
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back();
    test_preset();
    test_wheel();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
